// File: rtl/soc.sv
// Minimal SoC: DMA handshake FSM writing then reading back one word of an
// internal RAM, plus an independent one-cycle registered peripheral byte path.
module soc #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_request,
  output logic        dma_ack,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_data_in,
  output logic [31:0] memory_data_out,
  output logic        memory_write_enable,
  input  logic [7:0]  peripheral_data_in,
  output logic [7:0]  peripheral_data_out
);

  typedef enum logic [2:0] {
    IDLE, GRANT, SETUP, WRITE, READ, DONE, RELEASE
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_idx;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [31:0]            mem [MEM_DEPTH];
  logic                   unused_addr_bits;

  assign addr_idx         = memory_address[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^memory_address[31:ADDR_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      dma_ack             <= 1'b0;
      memory_write_enable <= 1'b0;
      memory_data_out     <= '0;
      idx                 <= '0;
    end else begin
      dma_ack             <= 1'b0;
      memory_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_request) begin
            state   <= GRANT;
            dma_ack <= 1'b1;
          end
        end
        GRANT: state <= SETUP;
        SETUP: begin
          state               <= WRITE;
          memory_write_enable <= 1'b1;
        end
        WRITE: begin
          // Index is captured with the write so READ returns the word just
          // written, whatever the master drives on the address bus afterwards.
          state <= READ;
          idx   <= addr_idx;
        end
        READ: begin
          state           <= DONE;
          dma_ack         <= 1'b1;
          memory_data_out <= mem[idx];
        end
        DONE: state <= RELEASE;
        RELEASE: begin
          if (!dma_request) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM has no reset; reset forces IDLE, which blocks any pending write.
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[addr_idx] <= memory_data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) peripheral_data_out <= '0;
    else       peripheral_data_out <= peripheral_data_in;
  end

endmodule

// File: tb/tb_soc.sv
// Bench for soc: directed plan steps plus randomized DMA transfers checked
// against a word-array memory model and fixed handshake timing.
module tb_soc;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_request;
  logic        dma_ack;
  logic [31:0] memory_address;
  logic [31:0] memory_data_in;
  logic [31:0] memory_data_out;
  logic        memory_write_enable;
  logic [7:0]  peripheral_data_in;
  logic [7:0]  peripheral_data_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] ref_mem [256];
  logic [31:0] exp_out;

  soc #(.ADDR_WIDTH(8), .MEM_DEPTH(256)) dut (
    .clk                 (clk),
    .reset               (reset),
    .dma_request         (dma_request),
    .dma_ack             (dma_ack),
    .memory_address      (memory_address),
    .memory_data_in      (memory_data_in),
    .memory_data_out     (memory_data_out),
    .memory_write_enable (memory_write_enable),
    .peripheral_data_in  (peripheral_data_in),
    .peripheral_data_out (peripheral_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transfer. Request is raised (or already high) with the FSM idle;
  // grant must appear at the next sample, completion four samples later.
  task automatic txn(input logic [31:0] a, input logic [31:0] d,
                     input bit drop_early, input int unsigned hold);
    logic [3:0]  ack_pat;
    logic [3:0]  we_pat;
    bit          held_ok;
    int unsigned extra_acks;
    dma_request = 1'b1;
    @(negedge clk);
    check("grant_ack", 32'(dma_ack), 32'd1);
    check("grant_we", 32'(memory_write_enable), 32'd0);
    memory_address = a;
    memory_data_in = d;
    ack_pat = '0;
    we_pat  = '0;
    held_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ack_pat[k] = dma_ack;
      we_pat[k]  = memory_write_enable;
      if (k < 3 && memory_data_out !== exp_out) held_ok = 1'b0;
      if (k == 0 && drop_early) dma_request = 1'b0;
      if (k == 2) begin
        memory_address = $urandom();
        memory_data_in = $urandom();
      end
    end
    ref_mem[a[7:0]] = d;
    exp_out = ref_mem[a[7:0]];
    check("ack_pattern", 32'(ack_pat), 32'b1000);
    check("we_pattern", 32'(we_pat), 32'b0010);
    check("out_hold", 32'(held_ok), 32'd1);
    check("readback", memory_data_out, exp_out);
    extra_acks = 0;
    for (int unsigned h = 0; h < hold; h++) begin
      @(negedge clk);
      if (dma_ack) extra_acks++;
    end
    dma_request = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (dma_ack) extra_acks++;
    end
    check("no_extra_ack", 32'(extra_acks), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  p;
    reset = 1'b1;
    dma_request = 1'b1;
    memory_address = '0;
    memory_data_in = '0;
    peripheral_data_in = 8'h00;
    exp_out = '0;
    #50;
    check("rst_ack", 32'(dma_ack), 32'd0);
    check("rst_we", 32'(memory_write_enable), 32'd0);
    check("rst_out", memory_data_out, 32'd0);
    check("rst_periph", 32'(peripheral_data_out), 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b0;

    txn(32'h0, 32'h12345678, 1'b0, 0);

    peripheral_data_in = 8'hAB;
    @(negedge clk);
    check("periph_1", 32'(peripheral_data_out), 32'hAB);
    @(negedge clk);
    check("periph_2", 32'(peripheral_data_out), 32'hAB);
    for (int i = 0; i < 8; i++) begin
      p = 8'($urandom());
      peripheral_data_in = p;
      @(negedge clk);
      check("periph_rand", 32'(peripheral_data_out), 32'(p));
    end

    txn(32'h0000_0042, 32'h0BADF00D, 1'b0, 20);
    txn(32'h0000_0005, 32'hDEADBEEF, 1'b0, 0);
    txn(32'h0000_0105, 32'hCAFEF00D, 1'b0, 0);
    check("alias_readback", memory_data_out, 32'hCAFEF00D);
    txn(32'h0000_0006, 32'h66666666, 1'b0, 0);
    check("isolation_word5", dut.mem[5], ref_mem[5]);
    txn(32'hFFFF_FF07, 32'h13572468, 1'b1, 0);

    // Reset while in SETUP: outputs clear with no clock edge in between.
    dma_request = 1'b1;
    @(negedge clk);
    memory_address = 32'h5;
    memory_data_in = 32'h99999999;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_ack", 32'(dma_ack), 32'd0);
    check("async_we", 32'(memory_write_enable), 32'd0);
    check("async_out", memory_data_out, 32'd0);
    exp_out = '0;
    dma_request = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", 32'(dma_ack), 32'd0);
    end
    txn(32'h0000_0010, 32'h10101010, 1'b0, 0);

    // Reset during WRITE before its closing edge: the word must not change.
    dma_request = 1'b1;
    @(negedge clk);
    memory_address = 32'h5;
    memory_data_in = 32'h77777777;
    repeat (2) @(negedge clk);
    check("write_we", 32'(memory_write_enable), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_we_clear", 32'(memory_write_enable), 32'd0);
    exp_out = '0;
    dma_request = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("lost_write", dut.mem[5], ref_mem[5]);

    for (int i = 0; i < 16; i++) begin
      a = $urandom() & 32'hFFFF_F00F;
      d = $urandom();
      txn(a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    check("final_word5", dut.mem[5], ref_mem[5]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
